// File: rtl/axil_wb_master_bridge.sv
// AXI4-Lite slave to Wishbone classic master bridge.
// One single-beat AXI transaction is turned into one Wishbone cycle; only one
// transaction is ever outstanding.
//
// Handshake semantics: a transfer on any AXI channel happens in the cycle
// where both valid and ready are high at the rising clock edge. awready/wready
// and arready are combinational grants that are only raised in IDLE. bvalid and
// rvalid are held with a stable payload until the matching ready is sampled high.
module axil_wb_master_bridge #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_W-1:0]   s_axi_awaddr,
   input  logic                s_axi_awvalid,
   output logic                s_axi_awready,
   input  logic [DATA_W-1:0]   s_axi_wdata,
   input  logic [DATA_W/8-1:0] s_axi_wstrb,
   input  logic                s_axi_wvalid,
   output logic                s_axi_wready,
   output logic [1:0]          s_axi_bresp,
   output logic                s_axi_bvalid,
   input  logic                s_axi_bready,
   input  logic [ADDR_W-1:0]   s_axi_araddr,
   input  logic                s_axi_arvalid,
   output logic                s_axi_arready,
   output logic [DATA_W-1:0]   s_axi_rdata,
   output logic [1:0]          s_axi_rresp,
   output logic                s_axi_rvalid,
   input  logic                s_axi_rready,
   output logic [ADDR_W-1:0]   wb_adr_o,
   output logic [DATA_W-1:0]   wb_dat_o,
   input  logic [DATA_W-1:0]   wb_dat_i,
   output logic                wb_we_o,
   output logic [DATA_W/8-1:0] wb_sel_o,
   output logic                wb_stb_o,
   output logic                wb_cyc_o,
   input  logic                wb_ack_i,
   input  logic                wb_err_i,
   output logic [2:0]          dbg_state
);

   localparam int SEL_W = DATA_W / 8;
   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WB_WR = 3'd1,
      WB_RD = 3'd2,
      BRESP = 3'd3,
      RRESP = 3'd4
   } state_t;

   state_t             state, state_nx;
   logic               prio_rd;      // 0: write wins a tie, 1: read wins
   logic [CNT_W-1:0]   tmo_cnt;
   logic [1:0]         resp;
   logic               grant_wr, grant_rd;
   logic               in_wb, end_ack, end_err, end_tmo, wb_end;
   logic               unused_addr_lsbs;

   // Byte-offset bits never reach the bus; the interconnect decodes words.
   assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};
   assign dbg_state        = state;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Arbitration, cycle termination, next state and handshake outputs.
   always_comb begin
      state_nx      = state;
      grant_wr      = 1'b0;
      grant_rd      = 1'b0;
      in_wb         = (state == WB_WR) || (state == WB_RD);
      end_err       = in_wb && wb_err_i;
      end_ack       = in_wb && wb_ack_i && !wb_err_i;
      end_tmo       = (TIMEOUT != 0) && in_wb && !wb_ack_i && !wb_err_i &&
                      (tmo_cnt == CNT_W'(TIMEOUT - 1));
      wb_end        = end_err || end_ack || end_tmo;
      if ((state == IDLE) && !rst) begin
         grant_wr = s_axi_awvalid && s_axi_wvalid && (!s_axi_arvalid || !prio_rd);
         grant_rd = s_axi_arvalid && !grant_wr;
      end
      s_axi_awready = grant_wr;
      s_axi_wready  = grant_wr;
      s_axi_arready = grant_rd;
      s_axi_bvalid  = (state == BRESP);
      s_axi_rvalid  = (state == RRESP);
      wb_cyc_o      = in_wb;
      wb_stb_o      = in_wb;
      case (state)
         IDLE:    if (grant_wr) state_nx = WB_WR;
                  else if (grant_rd) state_nx = WB_RD;
         WB_WR:   if (wb_end) state_nx = BRESP;
         WB_RD:   if (wb_end) state_nx = RRESP;
         BRESP:   if (s_axi_bready) state_nx = IDLE;
         RRESP:   if (s_axi_rready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Request capture, tie-break flag, timeout counter and response payload.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_adr_o    <= '0;
         wb_dat_o    <= '0;
         wb_sel_o    <= '0;
         wb_we_o     <= 1'b0;
         prio_rd     <= 1'b0;
         tmo_cnt     <= '0;
         resp        <= 2'b00;
         s_axi_rdata <= '0;
      end else begin
         if (grant_wr) begin
            wb_adr_o <= {s_axi_awaddr[ADDR_W-1:2], 2'b00};
            wb_dat_o <= s_axi_wdata;
            wb_sel_o <= s_axi_wstrb;
            wb_we_o  <= 1'b1;
         end else if (grant_rd) begin
            wb_adr_o <= {s_axi_araddr[ADDR_W-1:2], 2'b00};
            wb_sel_o <= {SEL_W{1'b1}};
            wb_we_o  <= 1'b0;
         end
         if (grant_wr || grant_rd) begin
            prio_rd <= ~prio_rd;
            tmo_cnt <= '0;
         end else if (in_wb && !wb_ack_i && !wb_err_i) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
         end
         if (wb_end) begin
            resp <= end_ack ? 2'b00 : 2'b10;
            if (state == WB_RD) s_axi_rdata <= end_ack ? wb_dat_i : '0;
         end
      end
   end

   assign s_axi_bresp = resp;
   assign s_axi_rresp = resp;

endmodule

// File: tb/tb_axil_wb_master_bridge.sv
// Bench for axil_wb_master_bridge: directed scenarios then randomized
// transactions, with a Wishbone slave and an expected-response queue.
module tb_axil_wb_master_bridge;

   localparam int TMO = 8;

   logic        clk, rst;
   logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
   logic [3:0]  s_axi_wstrb;
   logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
   logic [1:0]  s_axi_bresp, s_axi_rresp;
   logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
   logic        s_axi_rvalid, s_axi_rready;
   logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
   logic        wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i, wb_err_i;
   logic [3:0]  wb_sel_o;
   logic [2:0]  dbg_state;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [33:0] exp_q[$];         // {resp, rdata}
   bit          prio_wr;          // reference tie-break: 1 = write wins next tie

   axil_wb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
      .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
      .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
      .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
      .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
      .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .dbg_state(dbg_state)
   );

   // Clock and global time limit.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wishbone slave: ends the cycle on stb cycle lat+1 (mode 0 ack, 1 err,
   // 2 err+ack, 3 never) and checks the bus on every stb cycle.
   task automatic run_wb(input bit is_wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int lat, input int mode,
                         input logic [31:0] rd_val, input bit other_pending);
      int          cnt;
      bit          done;
      bit          timed_out;
      int          exp_cnt;
      logic [1:0]  e_resp;
      logic [31:0] e_rdata;
      timed_out = (mode == 3) || (lat + 1 > TMO);
      exp_cnt   = timed_out ? TMO : lat + 1;
      e_resp    = (timed_out || mode != 0) ? 2'b10 : 2'b00;
      e_rdata   = (is_wr || e_resp != 2'b00) ? 32'h0 : rd_val;
      exp_q.push_back({e_resp, e_rdata});
      cnt  = 0;
      done = 0;
      for (int k = 0; k < 40 && !done; k++) begin
         if (wb_cyc_o) begin
            cnt++;
            chk("wb_stb", wb_stb_o, 1);
            chk("wb_adr", wb_adr_o, {addr[31:2], 2'b00});
            chk("wb_we", wb_we_o, is_wr);
            chk("wb_sel", wb_sel_o, is_wr ? strb : 4'hF);
            if (is_wr) chk("wb_dat", wb_dat_o, data);
            if (other_pending)
               chk("busy_ready", {s_axi_awready, s_axi_wready, s_axi_arready}, 0);
            if (cnt == lat + 1 && mode != 3) begin
               wb_ack_i = (mode != 1);
               wb_err_i = (mode != 0);
               wb_dat_i = rd_val;
            end else begin
               wb_dat_i = $urandom;
            end
            tick();
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
         end else begin
            done = 1;
         end
      end
      chk("stb_cycles", cnt, exp_cnt);
   endtask

   // AXI master side of the response channel; ready raised after rdy_delay cycles.
   task automatic run_resp(input bit is_wr, input int rdy_delay, input bit late_ack);
      logic [33:0] e;
      e = exp_q.pop_front();
      for (int d = 0; d <= rdy_delay; d++) begin
         if (late_ack && d == 0) wb_ack_i = 1'b1;
         if (d == rdy_delay) begin
            if (is_wr) s_axi_bready = 1'b1;
            else       s_axi_rready = 1'b1;
         end
         chk("cyc_low_in_resp", wb_cyc_o, 0);
         if (is_wr) begin
            chk("bvalid", s_axi_bvalid, 1);
            chk("rvalid_quiet", s_axi_rvalid, 0);
            chk("bresp", s_axi_bresp, e[33:32]);
         end else begin
            chk("rvalid", s_axi_rvalid, 1);
            chk("bvalid_quiet", s_axi_bvalid, 0);
            chk("rresp", s_axi_rresp, e[33:32]);
            chk("rdata", s_axi_rdata, e[31:0]);
         end
         tick();
         wb_ack_i = 1'b0;
      end
      s_axi_bready = 1'b0;
      s_axi_rready = 1'b0;
      chk("bvalid_done", s_axi_bvalid, 0);
      chk("rvalid_done", s_axi_rvalid, 0);
      chk("cyc_done", wb_cyc_o, 0);
   endtask

   // One lone request from IDLE through to the accepted response.
   task automatic single(input bit is_wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int lat, input int mode,
                         input logic [31:0] rd_val, input int rdy_delay);
      if (is_wr) begin
         s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
         s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
      end else begin
         s_axi_araddr = addr; s_axi_arvalid = 1'b1;
      end
      #1;
      chk("awready", s_axi_awready, is_wr);
      chk("wready", s_axi_wready, is_wr);
      chk("arready", s_axi_arready, !is_wr);
      prio_wr = !prio_wr;
      tick();
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
      run_wb(is_wr, addr, data, strb, lat, mode, rd_val, 0);
      run_resp(is_wr, rdy_delay, mode == 3);
   endtask

   // Write and read requested in the same IDLE cycle.
   task automatic pair(input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] ra,
                       input logic [31:0] rd_val);
      bit first_wr;
      s_axi_awaddr = wa; s_axi_wdata = wd; s_axi_wstrb = 4'hF;
      s_axi_araddr = ra;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
      #1;
      first_wr = prio_wr;
      chk("tie_awready", s_axi_awready, first_wr);
      chk("tie_arready", s_axi_arready, !first_wr);
      prio_wr = !prio_wr;
      tick();
      if (first_wr) begin s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; end
      else s_axi_arvalid = 1'b0;
      run_wb(first_wr, first_wr ? wa : ra, wd, 4'hF, $urandom_range(0, 3), 0, rd_val, 1);
      run_resp(first_wr, 0, 0);
      #1;
      chk("lone_awready", s_axi_awready, !first_wr);
      chk("lone_arready", s_axi_arready, first_wr);
      prio_wr = !prio_wr;
      tick();
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
      run_wb(!first_wr, first_wr ? ra : wa, wd, 4'hF, $urandom_range(0, 3), 0, rd_val, 0);
      run_resp(!first_wr, $urandom_range(0, 2), 0);
   endtask

   function automatic logic [73:0] all_outputs();
      return {s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid, s_axi_arready,
              s_axi_rdata, s_axi_rresp, s_axi_rvalid, wb_adr_o[0], wb_dat_o[0], wb_we_o,
              wb_sel_o, wb_stb_o, wb_cyc_o, wb_adr_o[31:1] != 0, wb_dat_o[31:1] != 0};
   endfunction

   // Directed and random stimulus, then the report.
   initial begin
      rst = 1'b1;
      s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
      s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
      s_axi_rready = 1'b0; wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
      prio_wr = 1'b1;
      repeat (3) tick();
      chk("reset_outputs", all_outputs(), 0);
      rst = 1'b0;
      tick();

      // Write with ack after two waits, then a read held by a slow rready.
      single(1, 32'h4000_0004, 32'h0000_0005, 4'hF, 2, 0, 32'h0, 0);
      single(0, 32'h4000_0000, 32'h0, 4'hF, 0, 0, 32'h0000_000A, 5);

      // Three simultaneous write/read pairs.
      for (int p = 0; p < 3; p++) pair(32'h4000_0010 + p * 4, 32'h1234_0000 + p,
                                       32'h4000_0020 + p * 4, 32'hBEEF_0000 + p);

      // No ack: abort after TMO stb cycles; a late ack is ignored.
      single(1, 32'h4000_0008, 32'hDEAD_BEEF, 4'h3, 0, 3, 32'h0, 1);
      // err and ack together on a read.
      single(0, 32'h4000_000C, 32'h0, 4'hF, 1, 2, 32'hFFFF_FFFF, 0);

      // Address without data (and data without address) is never accepted.
      s_axi_awaddr = 32'h4000_0030; s_axi_awvalid = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk("aw_only_ready", {s_axi_awready, s_axi_wready}, 0);
         tick();
         chk("aw_only_cyc", wb_cyc_o, 0);
      end
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("w_only_ready", {s_axi_awready, s_axi_wready}, 0);
         tick();
         chk("w_only_cyc", wb_cyc_o, 0);
      end
      s_axi_wvalid = 1'b0;
      single(1, 32'h4000_0033, 32'h0000_00AA, 4'h1, 0, 1, 32'h0, 0);

      // Stray ack/err outside a cycle.
      wb_ack_i = 1'b1; wb_err_i = 1'b1;
      tick();
      wb_ack_i = 1'b0; wb_err_i = 1'b0;
      tick();
      chk("stray_ack", {wb_cyc_o, s_axi_bvalid, s_axi_rvalid}, 0);

      // Reset in the middle of a read cycle.
      s_axi_araddr = 32'h4000_0040; s_axi_arvalid = 1'b1;
      #1;
      chk("rst_rd_arready", s_axi_arready, 1);
      tick();
      s_axi_arvalid = 1'b0;
      tick();
      chk("rst_rd_cyc", wb_cyc_o, 1);
      rst = 1'b1;
      tick();
      chk("rst_mid_outputs", all_outputs(), 0);
      rst = 1'b0;
      prio_wr = 1'b1;
      wb_ack_i = 1'b1; wb_dat_i = 32'h5555_5555;
      tick();
      wb_ack_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk("rst_no_resp", {s_axi_rvalid, s_axi_bvalid, wb_cyc_o}, 0);
         tick();
      end

      // Randomized traffic.
      for (int t = 0; t < 24; t++) begin
         int r, mode;
         r = $urandom_range(0, 9);
         mode = (r < 7) ? 0 : r - 6;
         single($urandom_range(0, 1), $urandom, $urandom, 4'($urandom_range(1, 15)),
                $urandom_range(0, 5), mode, $urandom, $urandom_range(0, 3));
         if (t % 6 == 5) pair($urandom, $urandom, $urandom, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
